// File: rtl/ff_pipe_arbiter.sv
// Round-robin arbiter feeding a fixed-depth tagged delay pipe.
// The pipe advances as a whole whenever the output stage is empty or being consumed.
module ff_pipe_arbiter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DEPTH = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid_i,
   input  logic [NREQ*WIDTH-1:0]     req_data_i,
   output logic [NREQ-1:0]           req_ready_o,
   output logic                      resp_valid_o,
   output logic [$clog2(NREQ)-1:0]   resp_id_o,
   output logic [WIDTH-1:0]          resp_data_o,
   input  logic                      resp_ready_i,
   output logic                      busy_o
);

   localparam int unsigned IDW = $clog2(NREQ);

   logic [DEPTH-1:0] vld;
   logic [IDW-1:0]   sid  [DEPTH];
   logic [WIDTH-1:0] sdat [DEPTH];

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   winner;
   logic             found;
   logic             adv;
   logic [WIDTH-1:0] win_data;
   int unsigned      cand;

   // Search requesters starting just after the last grant.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = (32'(ptr) + off) % NREQ;
         if (!found && req_valid_i[IDW'(cand)]) begin
            found  = 1'b1;
            winner = IDW'(cand);
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (winner == IDW'(k)) begin
            win_data = req_data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign adv = ~vld[DEPTH-1] | resp_ready_i;

   // Ready is suppressed during reset so nothing appears accepted while the pipe is cleared.
   assign req_ready_o = (adv && found && !rst) ? (NREQ'(1) << winner) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         ptr <= IDW'(NREQ - 1);
         for (int i = 0; i < DEPTH; i++) begin
            sid[i]  <= '0;
            sdat[i] <= '0;
         end
      end else if (adv) begin
         vld[0]  <= found;
         sid[0]  <= found ? winner : '0;
         sdat[0] <= found ? win_data : '0;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i]  <= vld[i-1];
            sid[i]  <= sid[i-1];
            sdat[i] <= sdat[i-1];
         end
         if (found) begin
            ptr <= winner;
         end
      end
   end

   assign resp_valid_o = vld[DEPTH-1];
   assign resp_id_o    = sid[DEPTH-1];
   assign resp_data_o  = sdat[DEPTH-1];
   assign busy_o       = |vld;

endmodule

// File: doc/ff_pipe_arbiter.md
# ff_pipe_arbiter

Round-robin arbiter and sequencer for the shared fixed-depth register pipeline. Up to NREQ requesters compete for a single entry slot of a DEPTH-stage, WIDTH-bit delay pipe. Each transfer carries its requester ID through the pipe. Results leave on one tagged response port with valid/ready backpressure, which stalls the whole pipe as a unit.

## Interface

Parameters:
- WIDTH, 4, data width of each pipe stage
- NREQ, 4, number of requesters (2..8)
- DEPTH, 3, number of pipe stages (1..8)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  NREQ  per-requester request valid
- req_data_i  input  NREQ*WIDTH  request data; requester k occupies bits [k*WIDTH +: WIDTH]
- req_ready_o  output  NREQ  one-hot or zero; bit k high means requester k's data is accepted this cycle
- resp_valid_o  output  1  output stage holds a valid entry
- resp_id_o  output  $clog2(NREQ)  requester ID of the output entry
- resp_data_o  output  WIDTH  data of the output entry
- resp_ready_i  input  1  downstream accepts the response
- busy_o  output  1  OR of all stage valid bits

## Operation

- Pipe contents: DEPTH stages, indexed 0..DEPTH-1. Each stage holds {valid, id, data}.
- Stage DEPTH-1 drives resp_valid_o, resp_id_o and resp_data_o directly from registers.
- Advance condition: adv = !valid[DEPTH-1] | resp_ready_i. This condition is combinational.
- When adv=1, every stage shifts by one at the clock edge, and stage 0 loads the granted request or a bubble (valid=0).
- When adv=0, every stage holds. Bubbles are not collapsed, so the pipe moves only as a whole.
- Arbitration uses a round-robin pointer ptr (last granted ID).
  - Candidate order is ptr+1, ptr+2, … modulo NREQ.
  - The first requester in that order with req_valid_i high wins.
- req_ready_o[k] = adv & (winner == k), and is combinational. No requester sees ready when adv=0.
- ptr updates to the winner only on an accepted grant (any req_ready_o bit high). Otherwise ptr holds.
- Requester data must stay stable while its valid is high and its ready is low. Ready never depends on data.
- Responses are dropped only by the handshake: an entry leaves stage DEPTH-1 when resp_valid_o & resp_ready_i.
- Simultaneous events:
  - An output pop and an input accept happen in the same cycle under adv.
  - All NREQ requesters valid together produce exactly one grant.

## Timing

- Reset (async assert; released synchronously by system):
  - All stage valid bits, IDs and data are 0.
  - ptr = NREQ-1, so requester 0 has first priority.
  - req_ready_o, resp_valid_o, resp_id_o, resp_data_o and busy_o all read 0.
- Reset mid-operation discards all in-flight entries immediately. No response is produced for them.
- Latency: a request accepted at edge E appears on resp_* after edge E+DEPTH-1, i.e. DEPTH cycles from the accept cycle, assuming no stall.
- Throughput: one accept per cycle while adv=1. A stall of N cycles delays every in-flight entry by N cycles.
- Fairness: a continuously valid requester is granted within NREQ accepted transfers.
- resp_* outputs are stable while resp_valid_o=1 and resp_ready_i=0.

## Test plan

- Reset checks (WIDTH=4, NREQ=4, DEPTH=3):
  - Assert rst mid-stream with 3 entries in flight. Required: all outputs read 0 asynchronously, and no response after release.
- Single requester:
  - Drive req 2 valid with data 0xA for one accepted cycle, resp_ready_i=1.
  - Required: req_ready_o=0b0100 that cycle, then resp_valid_o=1, id=2, data=0xA exactly 3 cycles later for one cycle.
- All-valid round robin from reset:
  - All 4 requesters valid continuously with data 0x1..0x4 (id k sends k+1), resp_ready_i=1.
  - Required grant order: 0,1,2,3,0,…
  - Required responses: id/data 0/0x1, 1/0x2, 2/0x3, 3/0x4 on consecutive cycles starting at cycle 3.
- Backpressure:
  - Fill the pipe with 3 entries, then hold resp_ready_i=0 for 5 cycles.
  - Required: req_ready_o=0, resp_* frozen, ptr unchanged, busy_o=1.
  - After release: the 3 entries drain in order, with no loss and no duplication.
- Bubble behaviour:
  - Send req 1 (0x5), then idle 1 cycle, then req 3 (0x9).
  - Required: responses 1/0x5 and 3/0x9 separated by one cycle of resp_valid_o=0.
- Skip-idle grant:
  - Set ptr=0 (last grant 0), with only requesters 0 and 3 valid.
  - Required: 3 is granted before 0.
